// File: rtl/cram_loader.sv
// cram_loader: serial CRAM chain writer with readback capture.
// Host words in, LSB-first bits out to the chain head.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, rb_en      begin a full chain load, readback mode
//   word_in/valid/ready     host configuration word stream
//   config_data_out/en      serial bit and shift enable to chain
//   config_data_in          serial bit from the chain tail
//   rb_word/valid/ready     readback word stream to host
//   busy, done        load in progress, completion pulse
module cram_loader #(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 1024,
  parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rb_en,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_data_out,
  output logic                  config_en,
  input  logic                  config_data_in,
  output logic [WORD_WIDTH-1:0] rb_word,
  output logic                  rb_valid,
  input  logic                  rb_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = $clog2(WORD_WIDTH + 1);
  localparam int MW = (CNT_WIDTH > IW) ? CNT_WIDTH : IW;
  localparam logic [MW-1:0] WW_M = MW'(WORD_WIDTH);

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT, RBWAIT, DONE
  } state_t;

  state_t                state;
  logic                  rb_mode;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [IW-1:0]         left;
  logic [IW-1:0]         take;
  logic [MW-1:0]         rem_m;
  logic [WORD_WIDTH-1:0] shreg;
  logic [WORD_WIDTH-1:0] rb_mask;
  logic [WORD_WIDTH-1:0] rb_reg;

  // Bits to shift for the next word: min(WORD_WIDTH, remaining).
  // Compared at a common width so tiny chains do not truncate.
  always_comb begin
    rem_m = MW'(remaining);
    take  = (rem_m < WW_M) ? IW'(rem_m) : IW'(WW_M);
  end

  assign word_ready      = (state == LOAD);
  assign config_en       = (state == SHIFT);
  assign config_data_out = config_en & shreg[0];
  assign rb_valid        = (state == RBWAIT);
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign rb_word         = rb_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rb_mode   <= 1'b0;
      remaining <= '0;
      left      <= '0;
      shreg     <= '0;
      rb_mask   <= '0;
      rb_reg    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            rb_mode   <= rb_en;
            remaining <= CNT_WIDTH'(CHAIN_LENGTH);
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (word_valid) begin
            shreg   <= word_in;
            left    <= take;
            rb_reg  <= '0;
            rb_mask <= WORD_WIDTH'(1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // One-hot mask steers the tail bit into its slot,
          // leaving unused high bits of a short word at 0.
          shreg   <= shreg >> 1;
          rb_reg  <= rb_reg |
                     (rb_mask & {WORD_WIDTH{config_data_in}});
          rb_mask <= rb_mask << 1;
          left    <= left - 1'b1;
          if (remaining != '0)
            remaining <= remaining - 1'b1;
          if (left == IW'(1)) begin
            if (rb_mode)
              state <= RBWAIT;
            else if (remaining == CNT_WIDTH'(1))
              state <= DONE;
            else
              state <= LOAD;
          end
        end
        RBWAIT: begin
          if (rb_ready)
            state <= (remaining == '0) ? DONE : LOAD;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cram_loader.sv
// tb_cram_loader: directed bench for cram_loader.
// Three instances (64, 40, 1 bit chains) with chain models.
module tb_cram_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  start_v;
  logic        rb_en;
  logic        word_valid;
  logic        rb_ready;
  logic [31:0] word_in;

  logic [2:0]  wr_v, en_v, do_v, rbv_v, busy_v, done_v;
  logic [31:0] rbw_v [3];

  logic [63:0] chain_a;
  logic [39:0] chain_b;
  logic        chain_c;
  logic [2:0]  ld;
  logic [63:0] ld_val;

  cram_loader #(.WORD_WIDTH(32), .CHAIN_LENGTH(64)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .rb_en(rb_en),
    .word_in(word_in), .word_valid(word_valid),
    .word_ready(wr_v[0]), .config_data_out(do_v[0]),
    .config_en(en_v[0]), .config_data_in(chain_a[0]),
    .rb_word(rbw_v[0]), .rb_valid(rbv_v[0]),
    .rb_ready(rb_ready), .busy(busy_v[0]), .done(done_v[0])
  );

  cram_loader #(.WORD_WIDTH(32), .CHAIN_LENGTH(40)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .rb_en(rb_en),
    .word_in(word_in), .word_valid(word_valid),
    .word_ready(wr_v[1]), .config_data_out(do_v[1]),
    .config_en(en_v[1]), .config_data_in(chain_b[0]),
    .rb_word(rbw_v[1]), .rb_valid(rbv_v[1]),
    .rb_ready(rb_ready), .busy(busy_v[1]), .done(done_v[1])
  );

  cram_loader #(.WORD_WIDTH(32), .CHAIN_LENGTH(1)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .rb_en(rb_en),
    .word_in(word_in), .word_valid(word_valid),
    .word_ready(wr_v[2]), .config_data_out(do_v[2]),
    .config_en(en_v[2]), .config_data_in(chain_c),
    .rb_word(rbw_v[2]), .rb_valid(rbv_v[2]),
    .rb_ready(rb_ready), .busy(busy_v[2]), .done(done_v[2])
  );

  // Behavioural chains: head enters at the top, tail is bit 0.
  always @(posedge clk)
    if (ld[0]) chain_a <= ld_val;
    else if (en_v[0]) chain_a <= {do_v[0], chain_a[63:1]};

  always @(posedge clk)
    if (ld[1]) chain_b <= ld_val[39:0];
    else if (en_v[1]) chain_b <= {do_v[1], chain_b[39:1]};

  always @(posedge clk)
    if (ld[2]) chain_c <= ld_val[0];
    else if (en_v[2]) chain_c <= do_v[2];

  int          sel = 0;
  logic        s_en, s_do, s_wr, s_rbv, s_busy, s_done;
  logic [31:0] s_rbw;
  assign s_en   = en_v[sel];
  assign s_do   = do_v[sel];
  assign s_wr   = wr_v[sel];
  assign s_rbv  = rbv_v[sel];
  assign s_busy = busy_v[sel];
  assign s_done = done_v[sel];
  assign s_rbw  = rbw_v[sel];

  int           cyc = 0;
  int           nen = 0, first_en = 0, last_en = 0;
  int           ndone = 0, last_done = 0, bad = 0, nrbv = 0;
  logic [127:0] strm = '0;
  logic         mon_clr = 1'b1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      nen <= 0; first_en <= 0; last_en <= 0;
      ndone <= 0; last_done <= 0; bad <= 0; nrbv <= 0;
      strm <= '0;
    end else begin
      if (s_en) begin
        strm[nen] <= s_do;
        nen       <= nen + 1;
        last_en   <= cyc;
        if (nen == 0) first_en <= cyc;
      end
      if (s_done) begin
        ndone     <= ndone + 1;
        last_done <= cyc;
      end
      if (s_rbv) nrbv <= nrbv + 1;
      if ((s_en && (s_wr || s_rbv || s_done || !s_busy)) ||
          (s_wr && s_rbv))
        bad <= bad + 1;
    end
  end

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] wq [4];
  logic [31:0] rbq [4];
  int          acc, nrb, hs_cyc;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk); mon_clr = 1'b1;
    @(negedge clk); mon_clr = 1'b0;
  endtask

  task automatic preload(input int which, input logic [63:0] v);
    @(negedge clk);
    ld_val    = v;
    ld[which] = 1'b1;
    @(negedge clk);
    ld = '0;
  endtask

  task automatic run_load(input int which, input logic rbe,
                          input int nw, input bit stall,
                          input int hold, input bit restart);
    int k, t, w;
    logic [31:0] rb_first;
    sel = which;
    clear_mon();
    k = 0; t = 0; w = 0; nrb = 0; hs_cyc = 0;
    rb_first = '0;
    @(negedge clk);
    start_v[which] = 1'b1;
    rb_en = rbe;
    @(negedge clk);
    start_v = '0;
    chk("start_rdy", s_wr, 1);
    while (s_busy && t < 3000) begin
      word_valid = (k < nw) &&
                   (!stall || ($urandom_range(0, 99) < 30));
      word_in = wq[k & 3];
      rb_ready = 1'b0;
      if (s_rbv) begin
        if (w == 0) rb_first = s_rbw;
        if (w < hold) w++;
        else rb_ready = 1'b1;
      end
      start_v = '0;
      if (restart && t == 20) start_v[which] = 1'b1;
      if (s_wr && word_valid) k++;
      if (s_rbv && rb_ready) begin
        chk("rb_stable", s_rbw, rb_first);
        rbq[nrb & 3] = s_rbw;
        nrb++;
        hs_cyc = cyc;
        w = 0;
      end
      @(negedge clk);
      t++;
    end
    word_valid = 1'b0;
    rb_ready = 1'b0;
    start_v = '0;
    chk("timeout", (t < 3000) ? 1 : 0, 1);
    acc = k;
    repeat (3) @(negedge clk);
    chk("idle_after", s_busy, 0);
  endtask

  initial begin
    int t;
    rst = 1'b1; start_v = '0; rb_en = 1'b0;
    word_valid = 1'b0; rb_ready = 1'b0; word_in = '0;
    ld = '0; ld_val = '0;
    preload(0, 64'h0);
    preload(1, 64'h0);
    preload(2, 64'h0);
    repeat (2) @(negedge clk);
    chk("rst_outs",
        {wr_v, en_v, do_v, rbv_v, busy_v, done_v}, 0);
    chk("rst_rbw", rbw_v[0] | rbw_v[1] | rbw_v[2], 0);
    rst = 1'b0;

    // Two full words, no readback, no stalls.
    wq[0] = 32'hDEADBEEF; wq[1] = 32'h01234567;
    run_load(0, 1'b0, 2, 1'b0, 0, 1'b0);
    chk("t1_nen", nen, 64);
    chk("t1_strm", strm[63:0], 64'h01234567_DEADBEEF);
    chk("t1_span", last_en - first_en, 64);
    chk("t1_done", ndone, 1);
    chk("t1_done_t", last_done - last_en, 1);
    chk("t1_chain", chain_a, 64'h01234567_DEADBEEF);
    chk("t1_words", acc, 2);
    chk("t1_bad", bad, 0);

    // Partial final word on a 40-bit chain.
    wq[0] = 32'hDEADBEEF; wq[1] = 32'hFFFFFFAB;
    run_load(1, 1'b0, 2, 1'b0, 0, 1'b0);
    chk("t2_nen", nen, 40);
    chk("t2_strm", strm[63:0], 64'h000000AB_DEADBEEF);
    chk("t2_chain", chain_b, 40'hAB_DEADBEEF);
    chk("t2_words", acc, 2);
    chk("t2_done", ndone, 1);

    // Readback of preloaded chain, host holds rb_ready low.
    preload(0, 64'hCAFEF00D_12345678);
    wq[0] = 32'h0; wq[1] = 32'h0;
    run_load(0, 1'b1, 2, 1'b0, 5, 1'b0);
    chk("t3_nrb", nrb, 2);
    chk("t3_rb0", rbq[0], 32'h12345678);
    chk("t3_rb1", rbq[1], 32'hCAFEF00D);
    chk("t3_nrbv", nrbv, 12);
    chk("t3_bad", bad, 0);
    chk("t3_nen", nen, 64);
    chk("t3_chain", chain_a, 64'h0);
    chk("t3_done", ndone, 1);
    chk("t3_done_t", last_done - hs_cyc, 1);

    // Random word_valid stalls plus a start while busy.
    wq[0] = 32'hDEADBEEF; wq[1] = 32'h01234567;
    run_load(0, 1'b0, 2, 1'b1, 0, 1'b1);
    chk("t4_nen", nen, 64);
    chk("t4_strm", strm[63:0], 64'h01234567_DEADBEEF);
    chk("t4_bad", bad, 0);
    chk("t4_done", ndone, 1);
    chk("t4_chain", chain_a, 64'h01234567_DEADBEEF);

    // Reset during the tenth shift of the first word.
    sel = 0;
    clear_mon();
    @(negedge clk);
    start_v[0] = 1'b1; rb_en = 1'b0;
    @(negedge clk);
    start_v = '0; word_valid = 1'b1; word_in = 32'hDEADBEEF;
    t = 0;
    while (nen < 9 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t5_reach", (t < 200) ? 1 : 0, 1);
    chk("t5_en10", s_en, 1);
    rst = 1'b1; word_valid = 1'b0;
    @(negedge clk);
    chk("t5_rst_out",
        {s_wr, s_en, s_do, s_rbv, s_busy, s_done, s_rbw}, 0);
    chk("t5_nen", nen, 10);
    rst = 1'b0;
    run_load(0, 1'b0, 2, 1'b0, 0, 1'b0);
    chk("t5_strm", strm[63:0], 64'h01234567_DEADBEEF);
    chk("t5_chain", chain_a, 64'h01234567_DEADBEEF);
    chk("t5_done", ndone, 1);

    // Single-bit chain with readback.
    preload(2, 64'h1);
    wq[0] = 32'hFFFFFFFE;
    run_load(2, 1'b1, 1, 1'b0, 2, 1'b0);
    chk("t6_words", acc, 1);
    chk("t6_nen", nen, 1);
    chk("t6_bit", strm[0], 0);
    chk("t6_nrb", nrb, 1);
    chk("t6_rb", rbq[0], 32'h1);
    chk("t6_chain", chain_c, 0);
    chk("t6_done", ndone, 1);
    chk("t6_done_t", last_done - hs_cyc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cram_loader.md
# cram_loader

Configuration-chain driver: the writing end of the serial CRAM chain that threads through every fpgacell. It accepts configuration words from a host on a valid/ready stream and serializes them LSB-first into the chain head with `config_en` asserted. It also captures the bits falling out of the chain tail into readback words, so the host can read back the previous configuration while loading a new one.

## Interface
- `WORD_WIDTH`, 32: width of host configuration and readback words.
- `CHAIN_LENGTH`, 1024: total CRAM bits in the chain, ≥1; the last word may be partial.
- `CNT_WIDTH`, $clog2(CHAIN_LENGTH+1): width of the chain bit counter.

Ports:
- `clk`  in  1  single clock for the loader and the CRAM chain.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle request to begin a full chain load; ignored while `busy`.
- `rb_en`  in  1  sampled with `start`; 1 = emit readback words.
- `word_in`  in  WORD_WIDTH  configuration word; bit 0 is shifted first.
- `word_valid`  in  1  `word_in` is valid.
- `word_ready`  out  1  loader accepts `word_in` this cycle.
- `config_data_out`  out  1  serial bit to the chain head `config_data_in`.
- `config_en`  out  1  chain shift enable; the chain shifts one bit per `clk` while it is high.
- `config_data_in`  in  1  serial bit from the chain tail `config_data_out`.
- `rb_word`  out  WORD_WIDTH  captured readback word; bit 0 is the first bit out of the tail.
- `rb_valid`  out  1  `rb_word` is valid.
- `rb_ready`  in  1  host accepts `rb_word`.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle pulse when the load is complete.

## Operation
- States: IDLE, LOAD, SHIFT, RBWAIT, DONE.
- IDLE:
  - `start` latches `rb_en`, clears `remaining` to CHAIN_LENGTH, and moves to LOAD.
  - `start` is ignored in any other state.
- LOAD:
  - `word_ready`=1.
  - On `word_valid`: latch `word_in` into the shift register and set `nbits` = min(WORD_WIDTH, `remaining`).
  - Clear the readback register, then go to SHIFT.
- SHIFT (`config_en`=1 every cycle):
  - `config_data_out` = shreg[0].
  - Sample `config_data_in` into readback bit position `nbits_done`.
  - Shift shreg right and decrement `remaining`.
  - After `nbits` cycles: go to RBWAIT if `rb_en`. Otherwise go to DONE if `remaining`==0, else to LOAD.
- RBWAIT:
  - `rb_valid`=1, with `rb_word` held stable; unused high bits of a partial final word are 0.
  - On `rb_ready`: go to DONE if `remaining`==0, else to LOAD.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- Bits of `word_in` above `nbits` in the final partial word are discarded.
- `config_en` is never high outside SHIFT, so the chain holds its value whenever the loader stalls.
- Arithmetic:
  - `remaining` counts down in CNT_WIDTH bits and never underflows.
  - Total shifts per load = exactly CHAIN_LENGTH.
  - Words consumed per load = ceil(CHAIN_LENGTH/WORD_WIDTH).
- Reset:
  - All outputs = 0: `word_ready`, `config_en`, `config_data_out`, `rb_word`, `rb_valid`, `busy`, `done`. State returns to IDLE.
  - A reset mid-load aborts immediately; no further `config_en`. Chain contents are undefined and the host must reload.

## Timing
- All outputs are driven from registers or decoded from state only; there are no combinational paths from inputs to outputs, except `word_ready`, which is decoded from state.
- Cycle numbering: cycle 0 = the cycle with `word_valid`&&`word_ready`.
  - Cycles 1..n: `config_en`=1, with `config_data_out` = word bit i-1 in cycle i.
  - The tail bit is sampled at the rising edge ending cycle i.
- `rb_en`=0: `word_ready` is high in cycle n+1, so back-to-back throughput is one word per WORD_WIDTH+1 cycles.
- `rb_en`=1: `rb_valid` rises in cycle n+1. The next `word_ready` comes in the cycle after the `rb_ready` handshake.
- `start` to first `word_ready`: 1 cycle.
- `done`: one cycle after the final shift when `rb_en`=0, or one cycle after the final readback handshake when `rb_en`=1.
- `word_valid` low in LOAD: stall with no shifting, indefinitely.
- `rb_ready` low: stall in RBWAIT, indefinitely.

## Test plan
- WORD_WIDTH=32, CHAIN_LENGTH=64, `rb_en`=0: words 0xDEADBEEF, 0x01234567 with `word_valid` always high.
  - Required: exactly 64 `config_en` cycles, with the serial stream = 0xDEADBEEF LSB-first then 0x01234567 LSB-first.
  - Required: the gap between the two shift bursts is exactly 1 cycle.
  - Required: `done` pulses once, and the behavioural chain model holds 0x01234567_DEADBEEF.
- CHAIN_LENGTH=40:
  - Required: the second word 0xFFFFFFAB shifts only 8 bits (0xAB).
  - Required: 40 shifts total, and the upper 24 bits never reach the chain.
- Readback, CHAIN_LENGTH=64, chain preloaded with 0xCAFEF00D_12345678 (tail-first order), `rb_en`=1, new data all zeros:
  - Required: `rb_word` 0x12345678 then 0xCAFEF00D.
  - Required: while `rb_ready` is held low 5 cycles, `rb_valid` stays high, `config_en` stays 0, and `word_ready` stays 0.
- Stalls: toggle `word_valid` randomly with a 30% duty.
  - Required: `config_en` only in SHIFT, the bit stream identical to the no-stall case, and a second `start` during `busy` ignored.
- Reset mid-shift: assert `rst` in cycle 10 of the first word.
  - Required: next cycle all outputs are 0 and the state is IDLE.
  - Required: a fresh `start` then completes a normal full load.
- CHAIN_LENGTH=1, `rb_en`=1:
  - Required: one word accepted, one `config_en` cycle, and `rb_word` = tail bit zero-extended.
  - Required: `done` pulses one cycle after the `rb_ready` handshake.
